// File: rtl/btb_update_arbiter.sv
// rtl/btb_update_arbiter.sv - collects up to two committed-branch BTB updates per cycle and drains one per cycle
module btb_update_arbiter #(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           cm_valid,
  input  logic [1:0][31:0]     cm_pc,
  input  logic [1:0][1:0]      cm_type,
  input  logic [1:0][31:0]     cm_npc,
  output logic                 cm_ready,
  input  logic                 btb_wr_block,
  output logic                 btb_commit,
  output logic [31:0]          btb_commit_pc,
  output logic [1:0]           btb_commit_pc_type,
  output logic [31:0]          btb_commit_npc,
  output logic [PTR_WIDTH:0]   occupancy
);

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  typ;
    logic [31:0] npc;
  } entry_t;

  localparam logic [PTR_WIDTH:0] READY_MAX = (PTR_WIDTH + 1)'(DEPTH - 2);

  entry_t [DEPTH-1:0]   mem_q, mem_d;
  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [PTR_WIDTH:0]   count_q, count_d;

  logic                 live0, live1, keep0;
  logic [1:0]           n_in;
  logic [PTR_WIDTH-1:0] wr_ptr;
  entry_t               head_entry;

  // Ready depends only on registered count so commit never sees a loop through cm_valid.
  assign cm_ready = (count_q <= READY_MAX);

  assign live0 = cm_valid[0] & (cm_type[0] != 2'b00) & cm_ready;
  assign live1 = cm_valid[1] & (cm_type[1] != 2'b00) & cm_ready;
  assign keep0 = live0 & ~(live1 & (cm_pc[0] == cm_pc[1]));
  assign n_in  = {1'b0, keep0} + {1'b0, live1};

  assign head_entry         = mem_q[head_q];
  assign btb_commit         = (count_q != '0) & ~btb_wr_block;
  assign btb_commit_pc      = (count_q != '0) ? head_entry.pc  : 32'h0;
  assign btb_commit_pc_type = (count_q != '0) ? head_entry.typ : 2'b00;
  assign btb_commit_npc     = (count_q != '0) ? head_entry.npc : 32'h0;
  assign occupancy          = count_q;

  always_comb begin
    mem_d  = mem_q;
    wr_ptr = tail_q;
    if (keep0) begin
      mem_d[wr_ptr] = '{pc: cm_pc[0], typ: cm_type[0], npc: cm_npc[0]};
      wr_ptr        = wr_ptr + 1'b1;
    end
    if (live1) begin
      mem_d[wr_ptr] = '{pc: cm_pc[1], typ: cm_type[1], npc: cm_npc[1]};
    end
    tail_d  = tail_q + PTR_WIDTH'(n_in);
    head_d  = head_q + PTR_WIDTH'(btb_commit);
    count_d = count_q + (PTR_WIDTH + 1)'(n_in) - (PTR_WIDTH + 1)'(btb_commit);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_btb_update_arbiter.sv
// tb/tb_btb_update_arbiter.sv - scoreboard bench for btb_update_arbiter
module tb_btb_update_arbiter;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  typ;
    logic [31:0] npc;
  } exp_t;

  logic            clock;
  logic            reset;
  logic [1:0]      cm_valid;
  logic [1:0][31:0] cm_pc;
  logic [1:0][1:0] cm_type;
  logic [1:0][31:0] cm_npc;
  logic            cm_ready;
  logic            btb_wr_block;
  logic            btb_commit;
  logic [31:0]     btb_commit_pc;
  logic [1:0]      btb_commit_pc_type;
  logic [31:0]     btb_commit_npc;
  logic [2:0]      occupancy;

  int   checks;
  int   failures;
  exp_t sb[$];

  btb_update_arbiter #(.DEPTH(4), .PTR_WIDTH(2)) dut (
    .clock              (clock),
    .reset              (reset),
    .cm_valid           (cm_valid),
    .cm_pc              (cm_pc),
    .cm_type            (cm_type),
    .cm_npc             (cm_npc),
    .cm_ready           (cm_ready),
    .btb_wr_block       (btb_wr_block),
    .btb_commit         (btb_commit),
    .btb_commit_pc      (btb_commit_pc),
    .btb_commit_pc_type (btb_commit_pc_type),
    .btb_commit_npc     (btb_commit_npc),
    .occupancy          (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [31:0] pc0, input logic [1:0] t0, input logic [31:0] n0,
                       input logic [31:0] pc1, input logic [1:0] t1, input logic [31:0] n1);
    cm_valid   = v;
    cm_pc[0]   = pc0;
    cm_type[0] = t0;
    cm_npc[0]  = n0;
    cm_pc[1]   = pc1;
    cm_type[1] = t1;
    cm_npc[1]  = n1;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0);
  endtask

  task automatic expect_push(input logic [31:0] pc, input logic [1:0] t, input logic [31:0] npc);
    sb.push_back('{pc: pc, typ: t, npc: npc});
  endtask

  task automatic chk_state(input string name, input logic rdy, input logic cmt, input logic [2:0] occ);
    chk({name, ".cm_ready"},   32'(cm_ready),   32'(rdy));
    chk({name, ".btb_commit"}, 32'(btb_commit), 32'(cmt));
    chk({name, ".occupancy"},  32'(occupancy),  32'(occ));
  endtask

  // Monitor: every drain strobe must match the oldest outstanding expected update.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (btb_commit === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL drain_unexpected: got pc 0x%0h npc 0x%0h, required no drain", btb_commit_pc, btb_commit_npc);
        end else begin
          e = sb.pop_front();
          if (btb_commit_pc !== e.pc || btb_commit_pc_type !== e.typ || btb_commit_npc !== e.npc) begin
            failures++;
            $display("FAIL drain_data: got pc 0x%0h type %0d npc 0x%0h, required pc 0x%0h type %0d npc 0x%0h",
                     btb_commit_pc, btb_commit_pc_type, btb_commit_npc, e.pc, e.typ, e.npc);
          end
        end
      end
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    btb_wr_block = 1'b0;
    idle();

    // 1: reset values, then ten quiet cycles
    #2;
    chk_state("reset", 1'b1, 1'b0, 3'd0);
    chk("reset.pc",   btb_commit_pc,              32'h0);
    chk("reset.type", 32'(btb_commit_pc_type),    32'h0);
    chk("reset.npc",  btb_commit_npc,             32'h0);
    #10;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_state("idle", 1'b1, 1'b0, 3'd0);
    end

    // 2: single update
    drive(2'b01, 32'h0000_1000, 2'b01, 32'h0000_2000, 32'h0, 2'b00, 32'h0);
    expect_push(32'h0000_1000, 2'b01, 32'h0000_2000);
    chk_state("single.pre", 1'b1, 1'b0, 3'd0);
    tick();
    idle();
    chk_state("single.c1", 1'b1, 1'b1, 3'd1);
    chk("single.c1.pc", btb_commit_pc, 32'h0000_1000);
    tick();
    chk_state("single.c2", 1'b1, 1'b0, 3'd0);

    // 3: pair drains older first on consecutive cycles
    drive(2'b11, 32'h100, 2'b10, 32'h400, 32'h104, 2'b10, 32'h800);
    expect_push(32'h100, 2'b10, 32'h400);
    expect_push(32'h104, 2'b10, 32'h800);
    tick();
    idle();
    chk_state("pair.c1", 1'b1, 1'b1, 3'd2);
    chk("pair.c1.pc", btb_commit_pc, 32'h100);
    tick();
    chk_state("pair.c2", 1'b1, 1'b1, 3'd1);
    chk("pair.c2.pc", btb_commit_pc, 32'h104);
    tick();
    chk_state("pair.c3", 1'b1, 1'b0, 3'd0);

    // 4a: non-branch in slot 0 is filtered
    drive(2'b11, 32'h300, 2'b00, 32'h700, 32'h304, 2'b11, 32'h900);
    expect_push(32'h304, 2'b11, 32'h900);
    tick();
    idle();
    chk_state("filter.c1", 1'b1, 1'b1, 3'd1);
    chk("filter.c1.pc", btb_commit_pc, 32'h304);
    tick();
    chk_state("filter.c2", 1'b1, 1'b0, 3'd0);

    // 4b: same-PC pair collapses to the younger slot
    drive(2'b11, 32'h200, 2'b01, 32'hA00, 32'h200, 2'b01, 32'hB00);
    expect_push(32'h200, 2'b01, 32'hB00);
    tick();
    idle();
    chk_state("collapse.c1", 1'b1, 1'b1, 3'd1);
    chk("collapse.c1.npc", btb_commit_npc, 32'hB00);
    tick();
    chk_state("collapse.c2", 1'b1, 1'b0, 3'd0);

    // 5: backpressure while the BTB port is blocked
    btb_wr_block = 1'b1;
    drive(2'b11, 32'h10, 2'b01, 32'h50, 32'h14, 2'b10, 32'h54);
    expect_push(32'h10, 2'b01, 32'h50);
    expect_push(32'h14, 2'b10, 32'h54);
    tick();
    chk_state("bp.c0", 1'b1, 1'b0, 3'd2);
    drive(2'b11, 32'h20, 2'b11, 32'h60, 32'h24, 2'b01, 32'h64);
    expect_push(32'h20, 2'b11, 32'h60);
    expect_push(32'h24, 2'b01, 32'h64);
    tick();
    chk_state("bp.c1", 1'b0, 1'b0, 3'd4);
    drive(2'b11, 32'h30, 2'b01, 32'h70, 32'h34, 2'b01, 32'h74);
    tick();
    chk_state("bp.c2", 1'b0, 1'b0, 3'd4);
    tick();
    chk_state("bp.c3", 1'b0, 1'b0, 3'd4);
    idle();
    btb_wr_block = 1'b0;
    #1;
    chk_state("bp.release", 1'b0, 1'b1, 3'd4);
    tick();
    chk_state("bp.d1", 1'b0, 1'b1, 3'd3);
    tick();
    chk_state("bp.d2", 1'b1, 1'b1, 3'd2);
    tick();
    chk_state("bp.d3", 1'b1, 1'b1, 3'd1);
    tick();
    chk_state("bp.d4", 1'b1, 1'b0, 3'd0);

    // 6: asynchronous reset with three buffered updates discards them
    btb_wr_block = 1'b1;
    drive(2'b11, 32'h40, 2'b01, 32'h80, 32'h44, 2'b01, 32'h84);
    tick();
    drive(2'b01, 32'h48, 2'b10, 32'h88, 32'h0, 2'b00, 32'h0);
    tick();
    idle();
    chk_state("rst.pre", 1'b0, 1'b0, 3'd3);
    btb_wr_block = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_state("rst.async", 1'b1, 1'b0, 3'd0);
    chk("rst.pc",   btb_commit_pc,           32'h0);
    chk("rst.type", 32'(btb_commit_pc_type), 32'h0);
    chk("rst.npc",  btb_commit_npc,          32'h0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_state("rst.after", 1'b1, 1'b0, 3'd0);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
